load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access unit for the RV32I core. Takes a decoded load or store from the execute stage and runs one request/ready transaction on the data-memory port. Byte/half/word loads are aligned and sign- or zero-extended. The finished load value drives the memory-data input of the writeback select multiplexer.

## Interface
Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a memory operation; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- funct3  in  3  RV32I width/sign code; sampled with start.
- addr  in  XLEN  byte address; sampled with start.
- store_data  in  XLEN  rs2 value; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  XLEN  extended load result, to writeback mux memory-data input.
- misaligned  out  1  alignment fault flag, valid with done (see Configuration).
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  write enable, valid while mem_req.
- mem_addr  out  XLEN  word address: {addr[31:2], 2'b00}.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  4  byte write strobes; 0 for loads.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- mem_rdata  in  XLEN  read word, valid when mem_ready is high on a load.

## Operation
- Decode funct3:
  - size = funct3[1:0]: 00 byte, 01 half, 1x word.
  - unsigned = funct3[2]; ignored for stores and words.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start=1 latches is_store, funct3, addr and store_data.
  - If aligned, go to ACCESS. If misaligned and the fault check is compiled in, go to DONE.
  - start while not in IDLE is ignored; there is no queueing.
- ACCESS: mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable.
  - mem_ready=0: stay in ACCESS.
  - mem_ready=1, load: register the extended load value, then go to DONE.
  - mem_ready=1, store: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in that cycle is ignored.
- Store lanes:
  - Byte: wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - Half: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - Word: wstrb = 4'b1111; wdata = store_data.
- Load extraction:
  - Byte from lane addr[1:0]; half from lane addr[1].
  - Sign-extend bit 7 or bit 15 unless unsigned; zero-extend otherwise.
- Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
- load_data holds its value until the next successful load. Stores and faults leave it unchanged.

## Timing
- Reset values: state IDLE, busy=0, done=0, misaligned=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, load_data=0.
- Reset asserted mid-ACCESS: the next edge forces IDLE and mem_req drops. The transaction is abandoned with no done pulse; memory must tolerate a withdrawn request.
- Minimum latency: start at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, done at cycle 2. Each wait state adds one cycle.
- Fault path: start at cycle 0, done and misaligned at cycle 1, no mem_req.
- load_data is valid in the done cycle and is registered, not combinational from mem_rdata.
- All outputs are registered or decoded from the state register only. There is no combinational path from mem_ready to mem_req.

## Configuration
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses skip memory and complete via DONE with misaligned=1.
  - misaligned clears on the next start.
- Undefined:
  - The misaligned output is tied to 0.
  - Halfword addresses are aligned down with addr[0] ignored; word addresses with addr[1:0] ignored.
  - Every access goes to memory.

## Structure
- Shared package lsu_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - funct3 constants for LB/LH/LW/LBU/LHU/SB/SH/SW.
- One combinational sub-module, load_aligner, takes (rdata, addr[1:0], size, unsigned) and returns the extended value.

## Test plan
- LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready high in first ACCESS cycle -> done at cycle 2, load_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
- SB addr 0x201, store_data 0x000000AB -> mem_addr 0x200, wstrb 4'b0010, wdata 0xABABABAB, mem_we=1.
- SH addr 0x202, store_data 0x1234, mem_ready held low 3 cycles -> request stable throughout, wstrb 4'b1100, done on the 5th cycle after start.
- LW addr 0x102 with LSU_MISALIGN_TRAP_EN -> no mem_req, done+misaligned at cycle 1. Without the macro -> mem_addr 0x100, normal load.
- Reset asserted while in ACCESS waiting on mem_ready -> next cycle IDLE, mem_req=0, no done pulse, load_data unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state, size and funct3 encodings for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - extracts and sign/zero-extends a byte or half from a read word
module load_aligner
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      byte_off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] value
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed lane, then extend it according to size and signedness
    always_comb begin
        lane_byte = rdata[7:0];
        case (byte_off)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        value = rdata;
        case (size)
            SIZE_BYTE: value = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: value = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-memory access FSM; alignment trap enabled by LSU_MISALIGN_TRAP_EN
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state;
    logic            op_store;
    logic            op_unsigned;
    logic [1:0]      op_size;
    logic [1:0]      op_off;
    logic [XLEN-1:0] aligned_value;

    logic [1:0]      req_size;
    logic [1:0]      req_off;
    logic [3:0]      req_strb;
    logic [XLEN-1:0] req_wdata;

    // Decode the incoming request: size, effective lane offset and store lanes.
    // Low address bits that would misalign a half/word are dropped here, so the
    // no-trap build simply aligns the access down.
    always_comb begin
        req_size  = funct3[1] ? SIZE_WORD : funct3[1:0];
        req_off   = 2'b00;
        req_strb  = 4'b1111;
        req_wdata = store_data;
        case (req_size)
            SIZE_BYTE: begin
                req_off   = addr[1:0];
                req_strb  = 4'b0001 << addr[1:0];
                req_wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                req_off   = {addr[1], 1'b0};
                req_strb  = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{store_data[15:0]}};
            end
            default: begin
                req_off   = 2'b00;
                req_strb  = 4'b1111;
                req_wdata = store_data;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_mis;
    logic mis_q;

    // Alignment fault: half on an odd byte, or word off a word boundary
    always_comb begin
        req_mis = ((req_size == SIZE_HALF) && addr[0]) ||
                  ((req_size == SIZE_WORD) && (addr[1:0] != 2'b00));
    end

    // Fault flag is captured with each accepted start and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (state == IDLE && start) begin
            mis_q <= req_mis;
        end
    end

    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

    load_aligner #(.XLEN(XLEN)) u_aligner (
        .rdata       (mem_rdata),
        .byte_off    (op_off),
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .value       (aligned_value)
    );

    // Main FSM: latch the request, hold the memory port until ready, pulse done
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_store    <= 1'b0;
            op_unsigned <= 1'b0;
            op_size     <= SIZE_BYTE;
            op_off      <= 2'b00;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= 4'b0000;
            load_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_store    <= is_store;
                        op_unsigned <= funct3[2];
                        op_size     <= req_size;
                        op_off      <= req_off;
                        mem_we      <= is_store;
                        mem_addr    <= {addr[XLEN-1:2], 2'b00};
                        mem_wdata   <= req_wdata;
                        mem_wstrb   <= is_store ? req_strb : 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
                        state       <= req_mis ? DONE : ACCESS;
`else
                        state       <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!op_store) begin
                            load_data <= aligned_value;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign mem_req = (state == ACCESS);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [31:0] load;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic [31:0] last_load = '0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_size(input logic [2:0] f3);
        return f3[1] ? 2'd2 : f3[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
        logic [1:0]  sz;
        logic [31:0] v;
        sz = model_size(f3);
        if (sz == 2'd0) begin
            v = rd >> (8 * a[1:0]);
            return f3[2] ? (v & 32'h0000_00FF) : {{24{v[7]}}, v[7:0]};
        end else if (sz == 2'd1) begin
            v = rd >> (16 * a[1]);
            return f3[2] ? (v & 32'h0000_FFFF) : {{16{v[15]}}, v[15:0]};
        end
        return rd;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] f3);
        logic [1:0] sz;
        sz = model_size(f3);
        if (sz == 2'd0) return 4'b0001 << a[1:0];
        if (sz == 2'd1) return 4'b0011 << (2 * a[1]);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [2:0] f3);
        logic [1:0] sz;
        sz = model_size(f3);
        if (sz == 2'd0) return {24'b0, sd[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'b0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    // Completion monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("load_data", load_data, e.load);
                check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            end
        end
    end

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int waits);
        logic [1:0] sz;
        logic       mis;
        logic       mis_eff;
        logic       got;
        int         lat;
        exp_t       e;
        sz  = model_size(f3);
        mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        mis_eff = mis;
`else
        mis_eff = 1'b0;
`endif
        if (!st && !mis_eff) last_load = model_load(rd, a, f3);
        e.load = last_load;
        e.mis  = mis_eff;
        sb.push_back(e);
        lat = mis_eff ? 1 : 2 + waits;

        @(posedge clk);
        #1;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_rdata = rd; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            mem_ready = !mis_eff && (cyc - 1 >= waits);
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("latency", 32'(cyc), 32'(lat));
                check("req_in_done", {31'b0, mem_req}, 32'd0);
            end else begin
                check("busy", {31'b0, busy}, 32'd1);
                check("mem_req", {31'b0, mem_req}, {31'b0, !mis_eff});
                if (!mis_eff) begin
                    check("mem_addr", mem_addr, {a[31:2], 2'b00});
                    check("mem_we", {31'b0, mem_we}, {31'b0, st});
                    check("mem_wstrb", {28'b0, mem_wstrb}, st ? {28'b0, model_strb(a, f3)} : 32'd0);
                    if (st) check("mem_wdata", mem_wdata, model_wdata(sd, f3));
                end
            end
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        mem_ready = 1'b0;
    endtask

    initial begin
        int dc;
        logic [2:0] ld_f3 [5];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_strb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_load", load_data, 32'd0);

        // Reset while waiting on memory: request withdrawn, no done, load_data untouched
        @(posedge clk);
        #1 start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
        mem_rdata = 32'h5555_5555; mem_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("abort_req_before", {31'b0, mem_req}, 32'd1);
        dc = done_count;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("abort_req", {31'b0, mem_req}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_load", load_data, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(dc));
        mem_ready = 1'b0;

        // Directed cases
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 1);
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h8011_2233, 0);
        run_op(1'b0, 3'b101, 32'h100, 32'h0, 32'h8011_A233, 0);
        run_op(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 0);
        run_op(1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 3);
        run_op(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 1);
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h1357_9BDF, 0);
        run_op(1'b0, 3'b001, 32'h105, 32'h0, 32'hF00D_8765, 0);
        run_op(1'b0, 3'b000, 32'h102, 32'h0, 32'h0044_0000, 0);

        // Random mix of loads and stores with 0..2 wait states
        for (int i = 0; i < 24; i++) begin
            logic        st;
            logic [2:0]  f3;
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            run_op(st, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
